render_rect_sched: RTL and testbench

- Sequences the shared rectangle-fill path that feeds the VGA plot port.
- Accepts rectangle draw requests (x, y, w, h, colour) from N_REQ independent requesters and grants one at a time, round-robin.
- Walks the granted rectangle pixel by pixel, one pixel per clock, emitting plot strobes.
- Pulses a per-requester done when the rectangle is finished.

---
 rtl/render_pkg.sv | 17 +
 rtl/render_rect_sched_rr_arbiter.sv | 31 +++
 rtl/render_rect_sched.sv | 135 +++++++++++++
 tb/tb_render_rect_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared definitions for the render blocks: field widths, screen size and
// the rectangle scheduler's state encoding.
package render_pkg;

  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int COLOUR_W_DEF = 3;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/render_rect_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first pending request after last_grant,
// wrapping around. Purely combinational; the caller holds last_grant.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    // NOTE: default every output first so no path leaves a value held,
    // which would infer a latch.
    grant     = '0;
    grant_idx = '0;
    // Walk the ring backwards so the last hit, which wins, is the nearest
    // requester after last_grant.
    for (int i = N_REQ; i >= 1; i--) begin
      int j;
      j = (int'(last_grant) + i) % N_REQ;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/render_rect_sched.sv
// Rectangle-fill scheduler: arbitrates N_REQ requesters round-robin and walks
// the granted rectangle one pixel per clock onto the VGA plot port.
module render_rect_sched
  import render_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*X_W-1:0]      req_x,
  input  logic [N_REQ*Y_W-1:0]      req_y,
  input  logic [N_REQ*X_W-1:0]      req_w,
  input  logic [N_REQ*Y_W-1:0]      req_h,
  input  logic [N_REQ*COLOUR_W-1:0] req_colour,
  output logic [N_REQ-1:0]          req_ack,
  output logic [N_REQ-1:0]          done,
  output logic                      busy,
  output logic                      plot,
  output logic [X_W-1:0]            plot_x,
  output logic [Y_W-1:0]            plot_y,
  output logic [COLOUR_W-1:0]       plot_colour
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [X_W:0] X_LIMIT = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIMIT = (Y_W+1)'(SCREEN_H);

  state_t state, next_state;

  logic [IDX_W-1:0]    last_grant;
  logic [N_REQ-1:0]    grant_oh;
  logic [IDX_W-1:0]    grant_idx;
  logic [X_W-1:0]      cur_x, cur_w, dx;
  logic [Y_W-1:0]      cur_y, cur_h, dy;
  logic [COLOUR_W-1:0] cur_c;

  logic [X_W-1:0] sel_w;
  logic [Y_W-1:0] sel_h;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;
  logic           dx_last, dy_last, in_bounds, capture;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant_oh),
    .grant_idx  (grant_idx)
  );

  assign capture = (state == S_IDLE) && (|req_valid);
  assign sel_w   = req_w[grant_idx*X_W +: X_W];
  assign sel_h   = req_h[grant_idx*Y_W +: Y_W];

  // Sums are one bit wider so off-screen pixels past the field width are
  // still recognised as clipped rather than wrapping back on screen.
  assign sum_x     = {1'b0, cur_x} + {1'b0, dx};
  assign sum_y     = {1'b0, cur_y} + {1'b0, dy};
  assign in_bounds = (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
  assign dx_last   = (dx == cur_w - X_W'(1));
  assign dy_last   = (dy == cur_h - Y_W'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (capture) next_state = (sel_w == '0 || sel_h == '0) ? S_DONE : S_DRAW;
      S_DRAW: if (dx_last && dy_last) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = '0;
    if (state == S_DONE) done[last_grant] = 1'b1;
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant  <= IDX_W'(N_REQ-1);
      req_ack     <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      cur_w       <= '0;
      cur_h       <= '0;
      cur_c       <= '0;
      dx          <= '0;
      dy          <= '0;
      plot        <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
    end else begin
      req_ack <= '0;
      plot    <= 1'b0;
      if (capture) begin
        last_grant <= grant_idx;
        req_ack    <= grant_oh;
        cur_x      <= req_x[grant_idx*X_W +: X_W];
        cur_y      <= req_y[grant_idx*Y_W +: Y_W];
        cur_w      <= sel_w;
        cur_h      <= sel_h;
        cur_c      <= req_colour[grant_idx*COLOUR_W +: COLOUR_W];
        dx         <= '0;
        dy         <= '0;
      end
      if (state == S_DRAW) begin
        plot        <= in_bounds;
        plot_x      <= sum_x[X_W-1:0];
        plot_y      <= sum_y[Y_W-1:0];
        plot_colour <= cur_c;
        if (dx_last) begin
          dx <= '0;
          dy <= dy + Y_W'(1);
        end else begin
          dx <= dx + X_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_render_rect_sched.sv
// Directed bench for render_rect_sched: single rectangle, contention,
// zero size, clipping, mid-draw reset and back-to-back requests.
module tb_render_rect_sched;

  localparam int N_REQ = 2;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*X_W-1:0]  req_x, req_w;
  logic [N_REQ*Y_W-1:0]  req_y, req_h;
  logic [N_REQ*C_W-1:0]  req_colour;
  logic [N_REQ-1:0]      req_ack, done;
  logic                  busy, plot;
  logic [X_W-1:0]        plot_x;
  logic [Y_W-1:0]        plot_y;
  logic [C_W-1:0]        plot_colour;

  int total = 0;
  int bad   = 0;

  render_rect_sched #(
    .N_REQ(N_REQ), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W),
    .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .req_colour(req_colour), .req_ack(req_ack), .done(done), .busy(busy),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int x, input int y, input int w,
                         input int h, input int c);
    req_x[i*X_W +: X_W]      = X_W'(x);
    req_y[i*Y_W +: Y_W]      = Y_W'(y);
    req_w[i*X_W +: X_W]      = X_W'(w);
    req_h[i*Y_W +: Y_W]      = Y_W'(h);
    req_colour[i*C_W +: C_W] = C_W'(c);
  endtask

  // Checks the control outputs every call and the pixel only when a plot is expected.
  task automatic expect_out(input string tag, input logic [1:0] ack, input logic [1:0] dn,
                            input logic bz, input logic pl, input int px, input int py,
                            input int pc);
    check({tag, ".ack"},  req_ack, ack);
    check({tag, ".done"}, done, dn);
    check({tag, ".busy"}, busy, bz);
    check({tag, ".plot"}, plot, pl);
    if (pl) begin
      check({tag, ".x"}, plot_x, px);
      check({tag, ".y"}, plot_y, py);
      check({tag, ".c"}, plot_colour, pc);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    int plots;
    int done_seen;
    resetn = 1'b0;
    req_valid = '0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    #2;
    expect_out("reset", 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    check("reset.plot_x", plot_x, 0);
    check("reset.plot_y", plot_y, 0);
    tick();
    resetn = 1'b1;

    // Single 2x2 rectangle from requester 0.
    set_req(0, 10, 5, 2, 2, 3);
    req_valid = 2'b01;
    tick();
    expect_out("single.cap", 2'b01, 2'b00, 1'b1, 1'b0, 0, 0, 0);
    req_valid = 2'b00;
    tick(); expect_out("single.p0", 2'b00, 2'b00, 1'b1, 1'b1, 10, 5, 3);
    tick(); expect_out("single.p1", 2'b00, 2'b00, 1'b1, 1'b1, 11, 5, 3);
    tick(); expect_out("single.p2", 2'b00, 2'b00, 1'b1, 1'b1, 10, 6, 3);
    tick(); expect_out("single.p3", 2'b00, 2'b01, 1'b1, 1'b1, 11, 6, 3);
    tick(); expect_out("single.end", 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);

    // Contention from a fresh reset: requester 0 first, then 1.
    do_reset();
    set_req(0, 1, 1, 1, 1, 1);
    set_req(1, 2, 2, 1, 1, 2);
    req_valid = 2'b11;
    tick(); expect_out("cont.cap0", 2'b01, 2'b00, 1'b1, 1'b0, 0, 0, 0);
    req_valid = 2'b10;
    tick(); expect_out("cont.done0", 2'b00, 2'b01, 1'b1, 1'b1, 1, 1, 1);
    tick(); expect_out("cont.idle0", 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    tick(); expect_out("cont.cap1", 2'b10, 2'b00, 1'b1, 1'b0, 0, 0, 0);
    req_valid = 2'b00;
    tick(); expect_out("cont.done1", 2'b00, 2'b10, 1'b1, 1'b1, 2, 2, 2);
    tick();
    // last_grant is now 1, so requester 0 leads the rotation again.
    req_valid = 2'b11;
    tick(); check("rot.first", req_ack, 2'b01);
    req_valid = 2'b10;
    tick(); check("rot.done_first", done, 2'b01);
    tick();
    tick(); check("rot.second", req_ack, 2'b10);
    req_valid = 2'b00;
    tick(); check("rot.done_second", done, 2'b10);
    tick();

    // Zero width: acknowledge and finish with no pixels.
    set_req(1, 20, 20, 0, 3, 4);
    req_valid = 2'b10;
    tick(); expect_out("zero.cap", 2'b10, 2'b10, 1'b1, 1'b0, 0, 0, 0);
    req_valid = 2'b00;
    tick(); expect_out("zero.end", 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);

    // Clipping at the bottom-right corner: 8 slots, 2 visible pixels.
    set_req(0, 158, 119, 4, 2, 5);
    req_valid = 2'b01;
    tick(); check("clip.ack", req_ack, 2'b01);
    req_valid = 2'b00;
    tick(); expect_out("clip.p0", 2'b00, 2'b00, 1'b1, 1'b1, 158, 119, 5);
    tick(); expect_out("clip.p1", 2'b00, 2'b00, 1'b1, 1'b1, 159, 119, 5);
    plots = 0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      plots += int'(plot);
      if (done != 2'b00 && i < 5) done_seen++;
    end
    check("clip.extra_plots", plots, 0);
    check("clip.early_done", done_seen, 0);
    check("clip.done", done, 2'b01);
    tick(); check("clip.idle", busy, 1'b0);

    // 10x10 rectangle aborted by reset after 7 plots.
    set_req(0, 0, 0, 10, 10, 6);
    req_valid = 2'b01;
    tick(); check("abort.ack", req_ack, 2'b01);
    req_valid = 2'b00;
    plots = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      plots += int'(plot);
    end
    check("abort.plots", plots, 7);
    resetn = 1'b0;
    #1;
    expect_out("abort.async", 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    tick(); tick();
    resetn = 1'b1;
    tick(); check("abort.no_done", done, 2'b00);
    set_req(0, 3, 3, 1, 1, 1);
    set_req(1, 4, 4, 1, 1, 2);
    req_valid = 2'b11;
    tick(); check("abort.regrant0", req_ack, 2'b01);

    // Back-to-back: requester 0 re-asserts after done while 1 waits.
    req_valid = 2'b10;
    tick(); expect_out("b2b.done0", 2'b00, 2'b01, 1'b1, 1'b1, 3, 3, 1);
    req_valid = 2'b11;
    tick(); expect_out("b2b.gap", 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    tick(); check("b2b.grant1", req_ack, 2'b10);
    req_valid = 2'b01;
    tick(); expect_out("b2b.done1", 2'b00, 2'b10, 1'b1, 1'b1, 4, 4, 2);
    tick(); check("b2b.gap2", busy, 1'b0);
    tick(); check("b2b.grant0", req_ack, 2'b01);
    req_valid = 2'b00;
    tick(); check("b2b.done0b", done, 2'b01);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
